// File: rtl/sap2_ctrl_pkg.sv
// Shared constants and the combinational decode for the SAP-2 controller.
// Decode maps (T-state, opcode, flags) to the 16-line control word.
package sap2_ctrl_pkg;

    localparam logic [3:0] OpLda = 4'h0;
    localparam logic [3:0] OpAdd = 4'h1;
    localparam logic [3:0] OpSub = 4'h2;
    localparam logic [3:0] OpSta = 4'h3;
    localparam logic [3:0] OpLdi = 4'h4;
    localparam logic [3:0] OpJmp = 4'h5;
    localparam logic [3:0] OpJc  = 4'h6;
    localparam logic [3:0] OpJz  = 4'h7;
    localparam logic [3:0] OpOut = 4'hE;
    localparam logic [3:0] OpHlt = 4'hF;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    typedef enum logic [3:0] {
        CwCp, CwEp, CwLa, CwEa, CwLm, CwSu, CwEu, CwCe,
        CwLb, CwLi, CwEi, CwLo, CwWe, CwLj, CwLf, CwHlt
    } ctrl_bit_e;

    typedef logic [15:0] ctrl_word_t;

    function automatic ctrl_word_t decode_word(input logic [5:0] t_state,
                                               input logic [3:0] opcode,
                                               input logic       flag_c,
                                               input logic       flag_z,
                                               input bit         cond_jumps);
        ctrl_word_t w;
        w = '0;
        unique case (t_state)
            T1: begin w[CwEp] = 1'b1; w[CwLm] = 1'b1; end
            T2: w[CwCp] = 1'b1;
            T3: begin w[CwCe] = 1'b1; w[CwLi] = 1'b1; end
            T4: begin
                case (opcode)
                    OpLda, OpAdd, OpSub, OpSta: begin w[CwEi] = 1'b1; w[CwLm] = 1'b1; end
                    OpLdi: begin w[CwEi] = 1'b1; w[CwLa] = 1'b1; end
                    OpJmp: begin w[CwEi] = 1'b1; w[CwLj] = 1'b1; end
                    OpJc: if (cond_jumps) begin w[CwEi] = 1'b1; w[CwLj] = flag_c; end
                    OpJz: if (cond_jumps) begin w[CwEi] = 1'b1; w[CwLj] = flag_z; end
                    OpOut: begin w[CwEa] = 1'b1; w[CwLo] = 1'b1; end
                    OpHlt: w[CwHlt] = 1'b1;
                    default: ;
                endcase
            end
            T5: begin
                case (opcode)
                    OpLda: begin w[CwCe] = 1'b1; w[CwLa] = 1'b1; end
                    OpAdd, OpSub: begin w[CwCe] = 1'b1; w[CwLb] = 1'b1; end
                    OpSta: begin w[CwEa] = 1'b1; w[CwWe] = 1'b1; end
                    default: ;
                endcase
            end
            T6: begin
                if (opcode == OpAdd || opcode == OpSub) begin
                    w[CwLa] = 1'b1;
                    w[CwEu] = 1'b1;
                    w[CwLf] = 1'b1;
                    w[CwSu] = (opcode == OpSub);
                end
            end
            default: ;
        endcase
        return w;
    endfunction

    // HLT is never a last step: the ring freezes at T4 instead.
    function automatic logic is_last_step(input logic [5:0] t_state, input logic [3:0] opcode);
        logic last;
        last = 1'b0;
        case (t_state)
            T4: last = !(opcode inside {OpLda, OpAdd, OpSub, OpSta, OpHlt});
            T5: last = (opcode inside {OpLda, OpSta});
            T6: last = 1'b1;
            default: last = 1'b0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/sap2_ring_counter.sv
// Six-bit one-hot T-state ring, falling-edge clocked, synchronous active-low clear to T1.
// Priority: clear, freeze, restart, advance.
module sap2_ring_counter
    import sap2_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       clear,
    input  logic       advance,
    input  logic       restart,
    input  logic       freeze,
    output logic [5:0] state
);

    always_ff @(negedge clock) begin
        if (!clear) begin
            state <= T1;
        end else if (freeze) begin
            state <= state;
        end else if (restart) begin
            state <= T1;
        end else if (advance) begin
            state <= {state[4:0], state[5]};
        end
    end

endmodule

// File: rtl/sap2_controller.sv
// SAP-2 controller: registered control word decoded from opcode, flags and the T-state ring.
// Everything updates on the falling edge so the datapath samples stable words on the rising edge.
module sap2_controller
    import sap2_ctrl_pkg::*;
#(
    parameter bit EARLY_END  = 1'b1,
    parameter bit COND_JUMPS = 1'b1
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [3:0] instruction,
    input  logic       flag_c,
    input  logic       flag_z,
    output logic       cp,
    output logic       ep,
    output logic       la,
    output logic       ea,
    output logic       lm,
    output logic       su,
    output logic       eu,
    output logic       ce,
    output logic       lb,
    output logic       li,
    output logic       ei,
    output logic       lo,
    output logic       we,
    output logic       lj,
    output logic       lf,
    output logic       hlt,
    output logic [5:0] t_state
);

    ctrl_word_t ctrl_q;
    ctrl_word_t ctrl_d;
    logic       last_step;
    logic       halted;
    logic       ring_advance;
    logic       ring_restart;
    logic       ring_freeze;

    assign halted = ctrl_q[CwHlt];

    always_comb begin
        ctrl_d       = decode_word(t_state, instruction, flag_c, flag_z, COND_JUMPS);
        last_step    = is_last_step(t_state, instruction);
        ring_advance = !halted;
        ring_restart = EARLY_END && last_step && !halted;
        // The HLT word itself freezes the ring so t_state stays at T4.
        ring_freeze  = halted || ctrl_d[CwHlt];
    end

    sap2_ring_counter u_ring (
        .clock  (clock),
        .clear  (clear),
        .advance(ring_advance),
        .restart(ring_restart),
        .freeze (ring_freeze),
        .state  (t_state)
    );

    always_ff @(negedge clock) begin
        if (!clear) begin
            ctrl_q <= '0;
        end else if (halted) begin
            ctrl_q        <= '0;
            ctrl_q[CwHlt] <= 1'b1;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign cp  = ctrl_q[CwCp];
    assign ep  = ctrl_q[CwEp];
    assign la  = ctrl_q[CwLa];
    assign ea  = ctrl_q[CwEa];
    assign lm  = ctrl_q[CwLm];
    assign su  = ctrl_q[CwSu];
    assign eu  = ctrl_q[CwEu];
    assign ce  = ctrl_q[CwCe];
    assign lb  = ctrl_q[CwLb];
    assign li  = ctrl_q[CwLi];
    assign ei  = ctrl_q[CwEi];
    assign lo  = ctrl_q[CwLo];
    assign we  = ctrl_q[CwWe];
    assign lj  = ctrl_q[CwLj];
    assign lf  = ctrl_q[CwLf];
    assign hlt = ctrl_q[CwHlt];

endmodule

// File: tb/tb_sap2_controller.sv
// Bench for sap2_controller: two instances (early-end with cond jumps, full-length without),
// each checked every cycle against a step-table model, plus a directed literal program.
module tb_sap2_controller;

    // Bench word layout: {cp,ep,la,ea,lm,su,eu,ce,lb,li,ei,lo,we,lj,lf,hlt}
    localparam logic [15:0] Cp  = 16'h8000;
    localparam logic [15:0] Ep  = 16'h4000;
    localparam logic [15:0] La  = 16'h2000;
    localparam logic [15:0] Ea  = 16'h1000;
    localparam logic [15:0] Lm  = 16'h0800;
    localparam logic [15:0] Su  = 16'h0400;
    localparam logic [15:0] Eu  = 16'h0200;
    localparam logic [15:0] Ce  = 16'h0100;
    localparam logic [15:0] Lb  = 16'h0080;
    localparam logic [15:0] Li  = 16'h0040;
    localparam logic [15:0] Ei  = 16'h0020;
    localparam logic [15:0] Lo  = 16'h0010;
    localparam logic [15:0] We  = 16'h0008;
    localparam logic [15:0] Lj  = 16'h0004;
    localparam logic [15:0] Lf  = 16'h0002;
    localparam logic [15:0] Hlt = 16'h0001;

    logic       clock = 1'b1;
    logic       clear = 1'b0;
    logic [3:0] instr_e = 4'h1;
    logic [3:0] instr_f = 4'hA;
    logic       flag_c = 1'b0;
    logic       flag_z = 1'b0;

    wire [15:0] word_e;
    wire [15:0] word_f;
    wire [5:0]  t_e;
    wire [5:0]  t_f;

    int checks = 0;
    int errors = 0;

    int step_e = 1;
    int step_f = 1;
    bit halted_e = 1'b0;
    bit halted_f = 1'b0;
    logic [15:0] exp_e;
    logic [15:0] exp_f;

    always #5 clock = ~clock;

    sap2_controller #(.EARLY_END(1'b1), .COND_JUMPS(1'b1)) dut_e (
        .clock(clock), .clear(clear), .instruction(instr_e), .flag_c(flag_c), .flag_z(flag_z),
        .cp(word_e[15]), .ep(word_e[14]), .la(word_e[13]), .ea(word_e[12]), .lm(word_e[11]),
        .su(word_e[10]), .eu(word_e[9]), .ce(word_e[8]), .lb(word_e[7]), .li(word_e[6]),
        .ei(word_e[5]), .lo(word_e[4]), .we(word_e[3]), .lj(word_e[2]), .lf(word_e[1]),
        .hlt(word_e[0]), .t_state(t_e)
    );

    sap2_controller #(.EARLY_END(1'b0), .COND_JUMPS(1'b0)) dut_f (
        .clock(clock), .clear(clear), .instruction(instr_f), .flag_c(flag_c), .flag_z(flag_z),
        .cp(word_f[15]), .ep(word_f[14]), .la(word_f[13]), .ea(word_f[12]), .lm(word_f[11]),
        .su(word_f[10]), .eu(word_f[9]), .ce(word_f[8]), .lb(word_f[7]), .li(word_f[6]),
        .ei(word_f[5]), .lo(word_f[4]), .we(word_f[3]), .lj(word_f[2]), .lf(word_f[1]),
        .hlt(word_f[0]), .t_state(t_f)
    );

    function automatic logic [15:0] spec_word(int step, logic [3:0] op, logic fc, logic fz,
                                              bit cond);
        logic [15:0] w;
        w = '0;
        case (step)
            1: w = Ep | Lm;
            2: w = Cp;
            3: w = Ce | Li;
            4: case (op)
                4'h0, 4'h1, 4'h2, 4'h3: w = Ei | Lm;
                4'h4: w = Ei | La;
                4'h5: w = Ei | Lj;
                4'h6: if (cond) w = fc ? (Ei | Lj) : Ei;
                4'h7: if (cond) w = fz ? (Ei | Lj) : Ei;
                4'hE: w = Ea | Lo;
                4'hF: w = Hlt;
                default: w = '0;
            endcase
            5: case (op)
                4'h0: w = Ce | La;
                4'h1, 4'h2: w = Ce | Lb;
                4'h3: w = Ea | We;
                default: w = '0;
            endcase
            6: case (op)
                4'h1: w = La | Eu | Lf;
                4'h2: w = La | Su | Eu | Lf;
                default: w = '0;
            endcase
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic int spec_len(logic [3:0] op, bit early);
        if (!early) return 6;
        case (op)
            4'h0, 4'h3: return 5;
            4'h1, 4'h2: return 6;
            default: return 4;
        endcase
    endfunction

    function automatic logic [5:0] onehot(int step);
        logic [5:0] r;
        r = 6'b000001;
        return r << (step - 1);
    endfunction

    task automatic model_step(input logic clr, input logic [3:0] op, input logic fc,
                              input logic fz, input bit early, input bit cond,
                              inout int step, inout bit halted, output logic [15:0] w);
        if (!clr) begin
            step = 1;
            halted = 1'b0;
            w = '0;
        end else if (halted) begin
            w = Hlt;
        end else begin
            w = spec_word(step, op, fc, fz, cond);
            if (step == 4 && op == 4'hF) halted = 1'b1;
            else if (step >= spec_len(op, early)) step = 1;
            else step = step + 1;
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_bus(input string name, input logic [15:0] w);
        checks++;
        if ($countones({w[14], w[12], w[9], w[8], w[5]}) > 1) begin
            errors++;
            $display("FAIL %s at %0t: got %h, more than one bus driver", name, $time, w);
        end
    endtask

    // Model advances on the same falling edge as the DUTs; compare just after it.
    always @(negedge clock) begin
        model_step(clear, instr_e, flag_c, flag_z, 1'b1, 1'b1, step_e, halted_e, exp_e);
        model_step(clear, instr_f, flag_c, flag_z, 1'b0, 1'b0, step_f, halted_f, exp_f);
        #1;
        chk("model_word_e", word_e, exp_e);
        chk("model_tstate_e", {10'b0, t_e}, {10'b0, onehot(step_e)});
        chk("model_word_f", word_f, exp_f);
        chk("model_tstate_f", {10'b0, t_f}, {10'b0, onehot(step_f)});
        chk_bus("bus_e", word_e);
        chk_bus("bus_f", word_f);
    end

    task automatic step(input string name, input logic [15:0] ew, input logic [5:0] et);
        @(negedge clock);
        #2;
        chk(name, word_e, ew);
        chk({name, "_t"}, {10'b0, t_e}, {10'b0, et});
    endtask

    task automatic fetch();
        step("fetch_t1", Ep | Lm, 6'b000010);
        step("fetch_t2", Cp, 6'b000100);
        step("fetch_t3", Ce | Li, 6'b001000);
    endtask

    function automatic logic [3:0] pick_op();
        logic [3:0] op;
        op = 4'($urandom_range(0, 15));
        if (op == 4'hF && $urandom_range(0, 2) != 0) op = 4'($urandom_range(0, 14));
        return op;
    endfunction

    initial begin
        step("reset", 16'h0000, 6'b000001);
        step("reset_hold", 16'h0000, 6'b000001);
        clear = 1'b1;
        fetch();
        step("add_t4", Ei | Lm, 6'b010000);
        chk("full_nop_t4_word", word_f, 16'h0000);
        chk("full_nop_t4_t", {10'b0, t_f}, 16'h0010);
        clear = 1'b0;
        step("mid_add_reset", 16'h0000, 6'b000001);
        clear = 1'b1;
        fetch();
        step("add_t4", Ei | Lm, 6'b010000);
        step("add_t5", Ce | Lb, 6'b100000);
        step("add_t6", La | Eu | Lf, 6'b000001);
        chk("full_nop_wrap_t", {10'b0, t_f}, 16'h0001);
        instr_e = 4'h2;
        fetch();
        step("sub_t4", Ei | Lm, 6'b010000);
        step("sub_t5", Ce | Lb, 6'b100000);
        step("sub_t6", La | Su | Eu | Lf, 6'b000001);
        instr_e = 4'h0;
        fetch();
        step("lda_t4", Ei | Lm, 6'b010000);
        step("lda_t5", Ce | La, 6'b000001);
        instr_e = 4'h7;
        flag_z = 1'b0;
        fetch();
        step("jz_not_taken", Ei, 6'b000001);
        flag_z = 1'b1;
        fetch();
        step("jz_taken", Ei | Lj, 6'b000001);
        instr_e = 4'h3;
        fetch();
        step("sta_t4", Ei | Lm, 6'b010000);
        step("sta_t5", Ea | We, 6'b000001);
        instr_e = 4'hA;
        fetch();
        step("nop_t4", 16'h0000, 6'b000001);
        instr_e = 4'hF;
        fetch();
        step("hlt_t4", Hlt, 6'b001000);
        instr_e = 4'h1;
        repeat (3) step("halted", Hlt, 6'b001000);
        clear = 1'b0;
        step("halt_release", 16'h0000, 6'b000001);
        clear = 1'b1;
        step("after_release", Ep | Lm, 6'b000010);

        // Opcodes only change while the model is in fetch, as the IR would.
        repeat (3000) begin
            @(posedge clock);
            flag_c = 1'($urandom_range(0, 1));
            flag_z = 1'($urandom_range(0, 1));
            if (halted_e || halted_f) clear = ($urandom_range(0, 3) != 0);
            else clear = ($urandom_range(0, 59) != 0);
            if ((halted_e || step_e <= 3) && $urandom_range(0, 1) == 1) instr_e = pick_op();
            if ((halted_f || step_f <= 3) && $urandom_range(0, 1) == 1) instr_f = pick_op();
        end
        @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sap2_controller.md
# sap2_controller

Parametrised successor to the SAP-1 six-state controller. Decodes the 4-bit opcode from the instruction register and drives all datapath control lines through a one-hot T-state sequencer. Adds memory store, load-immediate, unconditional and conditional jumps, ALU flag capture, optional early cycle termination, and a sticky halt. Sits between the instruction register/flag register and every load/enable pin of the datapath.

## Interface
- EARLY_END, 1: 1 restarts at T1 after an instruction's last active step; 0 always runs T1..T6.
- COND_JUMPS, 1: 1 enables JC/JZ; 0 decodes them as NOP.

- clock, in, 1: system clock. All state and outputs update on its falling edge.
- clear, in, 1: reset, synchronous, active-low.
- instruction, in, 4: opcode field from the instruction register.
- flag_c, in, 1: carry flag from the flag register.
- flag_z, in, 1: zero flag from the flag register.
- cp, ep, la, ea, lm, su, eu, ce, lb, li, ei, lo, out, 1 each: SAP-1 control lines, same meaning as before.
- we, out, 1: RAM write enable.
- lj, out, 1: program counter parallel load from the bus.
- lf, out, 1: flag register load.
- hlt, out, 1: halt, sticky.
- t_state, out, 6: current one-hot T-state, T1 = bit 0.

## Operation
- Opcodes: LDA 0000, ADD 0001, SUB 0010, STA 0011, LDI 0100, JMP 0101, JC 0110, JZ 0111, OUT 1110, HLT 1111. All others decode as NOP.
- Fetch is the same for every opcode:
  - T1: ep, lm.
  - T2: cp.
  - T3: ce, li.
- T4:
  - LDA/ADD/SUB/STA: ei, lm.
  - LDI: ei, la. Last step.
  - JMP: ei, lj. Last step.
  - JC: ei, lj only if flag_c=1. Last step.
  - JZ: ei, lj only if flag_z=1. Last step.
  - OUT: ea, lo. Last step.
  - NOP: no lines. Last step.
  - HLT: hlt.
- T5:
  - LDA: ce, la. Last step.
  - ADD/SUB: ce, lb.
  - STA: ea, we. Last step.
- T6:
  - ADD: la, eu, lf.
  - SUB: la, su, eu, lf.
- Flags are sampled at the falling edge that produces the T4 word. A not-taken JC/JZ still ends at T4.
- EARLY_END=1: the falling edge after a last step loads T1.
- EARLY_END=0: remaining steps up to T6 emit all-zero words, then T1.
- Halt:
  - Once hlt=1, t_state freezes and every other output is 0.
  - hlt stays 1 until clear=0. The instruction input is ignored while halted.
  - Opcode 1111 is acted on only at T4, never in T1–T3.
- Reset (clear=0 at a falling edge): t_state=000001, all control outputs and hlt = 0. Reset overrides halt and any mid-instruction state.
- At most one of ea, eu, ei, ce, ep drives the bus in any word. The bench checks this as an invariant.

## Timing
- Outputs are registered and change only on falling edges. Each word is stable around the following rising edge, where the datapath samples.
- The falling edge with t_state=Tk captures Tk's word and advances to Tk+1 (or T1).
- The first falling edge with clear=1 after reset outputs the T1 word.
- Instruction cycle lengths with EARLY_END=1:
  - LDI, JMP, JC, JZ, OUT, NOP: 4 clocks.
  - LDA, STA: 5 clocks.
  - ADD, SUB: 6 clocks.
  - With EARLY_END=0, every instruction takes 6 clocks.
- HLT: hlt rises with the T4 word and t_state stays at T4 from then on.
- clear is sampled only on falling edges; no asynchronous path exists.

## Structure
- Package sap2_ctrl_pkg holds:
  - opcode constants;
  - the T1..T6 one-hot constants;
  - a control-word bit-index enum for all 16 lines.
- Decode is a pure function of (t_state, opcode, flags, params) returning the 16-bit control word.
- Sub-module sap2_ring_counter:
  - 6-bit one-hot;
  - synchronous active-low clear to T1;
  - inputs advance, restart and freeze;
  - wraps T6→T1.

## Test plan
- Reset mid-ADD at T5 (clear=0 for one falling edge) → t_state=000001, all outputs 0. Next edge: ep=lm=1.
- LDA then ADD then SUB, EARLY_END=1:
  - LDA is 5 clocks; ADD and SUB are 6 clocks each.
  - ADD T6 word is la,eu,lf; SUB T6 word is la,su,eu,lf.
  - Fetch of the next instruction starts on the very next edge.
- JZ with flag_z=0, then JZ with flag_z=1:
  - first: T4 word has ei only, lj=0;
  - second: ei and lj both 1;
  - both cycles are 4 clocks.
- Same program with EARLY_END=0 → every cycle is 6 clocks; the extra steps are all-zero words.
- STA, then opcode 1010 → STA T5 word is ea,we. Opcode 1010 runs as a 4-clock NOP with no lines set in T4.
- HLT, then change instruction to 0001 → hlt=1 from T4, t_state stuck at 001000, other outputs 0. Next clear=0 releases it.
